floating_mulsub: RTL and testbench
==================================

// Module: floating_mulsub
// PURPOSE
// - IEEE-754 single-precision multiply-subtract: result = (A * B) - C.
// - Unfused: the product is rounded to single precision before the subtraction.
// - Two-stage pipelined block inside the floating-point ALU.
// - Operands are presented in parallel every enabled cycle.
// PARAMETERS
// - none (format fixed: 1 sign, 8 exponent bits with bias 127, 23 fraction bits)
// PORTS
// - clk     in   1   clock, all state updates on rising edge
// - rst     in   1   reset, synchronous, active-high
// - EN      in   1   pipeline advance enable
// - A       in   32  multiplicand (IEEE-754 single)
// - B       in   32  multiplier (IEEE-754 single)
// - C       in   32  subtrahend (IEEE-754 single)
// - result  out  32  registered A*B-C (IEEE-754 single)
// - valid   out  1   only when FMS_VALID_OUT_EN is defined (see CONFIGURATION)
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-high.
// - rst=1 at a rising edge:
//   - clears both pipeline stages; result=32'h0000_0000.
//   - rst has priority over EN.
//   - reset mid-operation discards all in-flight operands.
// - EN=1 at an edge: A/B/C are captured into stage 1 and stage 1 advances to stage 2 (result).
// - EN=0: every register holds its value (stall); result is stable.
// - Latency: operands sampled at enabled edge k appear on result after enabled edge k+1.
//   - Throughput: one operation per enabled cycle.
// - Stage 1, multiply:
//   - sign = sA^sB; exponent = eA+eB-127.
//   - 24x24 mantissa product (hidden 1 restored); normalize by at most 1 bit.
//   - round to nearest, ties-to-even, using guard/round/sticky bits.
//   - carry C forward unchanged.
// - Stage 2, subtract:
//   - flip the sign of C; align the smaller exponent with guard/round/sticky bits.
//   - add/subtract the magnitudes; leading-zero normalize.
//   - round to nearest, ties-to-even; handle mantissa overflow after rounding.
// - Denormals: denormal inputs are treated as signed zero; denormal results are flushed to signed zero.
// - Exact-zero difference returns +0 (32'h0000_0000). (-0)-(+0) returns -0.
// - Overflow, in either stage: exponent >= 255 gives sign,8'hFF,23'h0 (infinity).
// - Underflow: exponent <= 0 gives signed zero.
// - Specials:
//   - any NaN input -> 32'h7FC0_0000.
//   - Inf*0 -> 32'h7FC0_0000.
//   - Inf - Inf of the same sign -> 32'h7FC0_0000.
//   - Inf product minus finite C -> Inf product.
//   - finite product minus Inf C -> -C.
// CONFIGURATION
// - Macro FMS_VALID_OUT_EN.
// - Defined:
//   - adds output port valid (1 bit).
//   - valid shift chain of depth 2, advanced on every clock edge (not gated by EN).
//   - the chain input is EN; valid is 1 exactly when result changed on the previous edge.
//   - valid resets to 0.
// - Not defined:
//   - no valid port and no extra logic.
//   - callers track latency themselves.
// TESTING
// - A=2.0(40000000) B=3.0(40400000) C=1.0(3F800000), EN=1
//   -> result=40A00000 (5.0) two edges later.
// - A=6.4(40CCCCCC) B=-0.5(BF000000) C=3.2(404CCCCC)
//   -> result=C0CCCCCC (-6.4).
// - A=1.5(3FC00000) B=2.0(40000000) C=3.0(40400000)
//   -> result=00000000 (+0).
// - A=7F800000(+Inf) B=0 C=1.0 -> 7FC00000.
// - A=7F000000 B=40000000 C=0 -> 7F800000 (overflow).
// - Hold EN=0 for 3 cycles while changing A/B/C -> result unchanged.
//   Then assert rst=1 -> result=0 after that edge, and stays 0 for 2 edges with EN=1 and zero inputs.

Source files
------------

// File: rtl/floating_mulsub.sv
// Two-stage unfused IEEE-754 single multiply-subtract: result = round(round(A*B) - C).
// Optional FMS_VALID_OUT_EN adds a 'valid' output driven by a two-deep EN history chain.
module floating_mulsub (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] C,
`ifdef FMS_VALID_OUT_EN
   output logic        valid,
`endif
   output logic [31:0] result
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // stage 1 registers: rounded product as a packed single plus the untouched subtrahend
   logic [31:0] s1_p, s1_c;

   logic        sa, sb;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   logic [47:0]        prod;
   logic [23:0]        m1;
   logic               g1, st1;
   logic [24:0]        m1_r;
   logic signed [9:0]  ex1;
   logic [22:0]        p_frac;
   logic               p_sign;
   logic [31:0]        p_word;

   assign {sa, ea, fa} = A;
   assign {sb, eb, fb} = B;
   assign a_nan  = (ea == 8'hFF) && (fa != '0);
   assign b_nan  = (eb == 8'hFF) && (fb != '0);
   assign a_inf  = (ea == 8'hFF) && (fa == '0);
   assign b_inf  = (eb == 8'hFF) && (fb == '0);
   assign a_zero = (ea == 8'h00);
   assign b_zero = (eb == 8'h00);

   always_comb begin
      p_sign = sa ^ sb;
      prod   = {1'b1, fa} * {1'b1, fb};
      ex1    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (prod[47]) begin
         m1  = prod[47:24];
         g1  = prod[23];
         st1 = |prod[22:0];
         ex1 = ex1 + 10'sd1;
      end else begin
         m1  = prod[46:23];
         g1  = prod[22];
         st1 = |prod[21:0];
      end
      m1_r = {1'b0, m1} + {24'd0, g1 & (st1 | m1[0])};
      if (m1_r[24])
         ex1 = ex1 + 10'sd1;
      p_frac = m1_r[24] ? m1_r[23:1] : m1_r[22:0];

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         p_word = QNAN;
      else if (a_inf || b_inf)
         p_word = {p_sign, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         p_word = {p_sign, 31'd0};
      else if (ex1 > 10'sd254)
         p_word = {p_sign, 8'hFF, 23'd0};
      else if (ex1 < 10'sd1)
         p_word = {p_sign, 31'd0};
      else
         p_word = {p_sign, ex1[7:0], p_frac};
   end

   logic        sp, sc;
   logic [7:0]  ep, ec;
   logic [22:0] fp, fc;
   logic        p_nan, c_nan, p_inf, c_inf, p_zero, c_zero;

   assign {sp, ep, fp} = s1_p;
   assign {sc, ec, fc} = s1_c;
   assign p_nan  = (ep == 8'hFF) && (fp != '0);
   assign c_nan  = (ec == 8'hFF) && (fc != '0);
   assign p_inf  = (ep == 8'hFF) && (fp == '0);
   assign c_inf  = (ec == 8'hFF) && (fc == '0);
   assign p_zero = (ep == 8'h00);
   assign c_zero = (ec == 8'h00);

   logic               p_big, sl, ss, eff_sub, found, g2, st2;
   logic [7:0]         el, es, d;
   logic [23:0]        ml, ms, m2;
   logic [63:0]        sh;
   logic [26:0]        small_al, norm;
   logic [27:0]        sum;
   logic [4:0]         lz;
   logic signed [9:0]  ex2;
   logic [24:0]        m2_r;
   logic [22:0]        r_frac;
   logic [31:0]        r_word;

   always_comb begin
      // operate on P + (-C): the larger magnitude fixes the exponent and result sign
      p_big = {ep, fp} >= {ec, fc};
      if (p_big) begin
         sl = sp;  el = ep; ml = {1'b1, fp};
         ss = ~sc; es = ec; ms = {1'b1, fc};
      end else begin
         sl = ~sc; el = ec; ml = {1'b1, fc};
         ss = sp;  es = ep; ms = {1'b1, fp};
      end
      d        = el - es;
      sh       = {ms, 40'd0} >> d;
      small_al = (d > 8'd26) ? 27'd1 : {sh[63:38], |sh[37:0]};
      eff_sub  = sl ^ ss;
      sum      = eff_sub ? ({1'b0, ml, 3'b000} - {1'b0, small_al})
                         : ({1'b0, ml, 3'b000} + {1'b0, small_al});

      lz    = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 27; i++) begin
         if (!found && sum[26 - i]) begin
            lz    = 5'(i);
            found = 1'b1;
         end
      end

      ex2 = $signed({2'b00, el});
      if (sum[27]) begin
         norm = {sum[27:2], sum[1] | sum[0]};
         ex2  = ex2 + 10'sd1;
      end else begin
         norm = sum[26:0] << lz;
         ex2  = ex2 - $signed({5'd0, lz});
      end
      m2   = norm[26:3];
      g2   = norm[2];
      st2  = norm[1] | norm[0];
      m2_r = {1'b0, m2} + {24'd0, g2 & (st2 | m2[0])};
      if (m2_r[24])
         ex2 = ex2 + 10'sd1;
      r_frac = m2_r[24] ? m2_r[23:1] : m2_r[22:0];

      if (p_nan || c_nan)
         r_word = QNAN;
      else if (p_inf && c_inf)
         r_word = (sp == sc) ? QNAN : {sp, 8'hFF, 23'd0};
      else if (p_inf)
         r_word = {sp, 8'hFF, 23'd0};
      else if (c_inf)
         r_word = {~sc, 8'hFF, 23'd0};
      else if (p_zero && c_zero)
         r_word = {sp & ~sc, 31'd0};
      else if (p_zero)
         r_word = {~sc, ec, fc};
      else if (c_zero)
         r_word = s1_p;
      else if (sum == '0)
         r_word = '0;
      else if (ex2 > 10'sd254)
         r_word = {sl, 8'hFF, 23'd0};
      else if (ex2 < 10'sd1)
         r_word = {sl, 31'd0};
      else
         r_word = {sl, ex2[7:0], r_frac};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_p   <= '0;
         s1_c   <= '0;
         result <= '0;
      end else if (EN) begin
         s1_p   <= p_word;
         s1_c   <= C;
         result <= r_word;
      end
   end

`ifdef FMS_VALID_OUT_EN
   logic v1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         valid <= 1'b0;
      end else begin
         v1    <= EN;
         valid <= v1;
      end
   end
`endif

endmodule

// File: tb/tb_floating_mulsub.sv
// Self-checking bench for floating_mulsub: directed vectors, randomized stream against an
// exact-arithmetic reference model, stall and reset behaviour.
module tb_floating_mulsub;

   logic        clk = 1'b0;
   logic        rst, EN;
   logic [31:0] A, B, C;
   logic [31:0] result;

   int vectors = 0;
   int errors  = 0;

   floating_mulsub dut (
      .clk(clk), .rst(rst), .EN(EN), .A(A), .B(B), .C(C), .result(result)
   );

   always #5 clk = ~clk;

   // Round an exact value mag*2^scale to single precision (RNE, flush, saturate to Inf).
   function automatic logic [31:0] round_pack(input logic s, input logic [319:0] mag, input int scale);
      int msb, be, sh;
      logic [319:0] m, rem, half;
      msb = -1;
      for (int i = 0; i < 320; i++) if (mag[i]) msb = i;
      if (msb < 0) return {s, 31'd0};
      be = msb + scale + 127;
      if (msb > 23) begin
         sh   = msb - 23;
         m    = mag >> sh;
         rem  = mag - (m << sh);
         half = 320'd1 << (sh - 1);
         if (rem > half || (rem == half && m[0])) m = m + 320'd1;
      end else begin
         m = mag << (23 - msb);
      end
      if (m[24]) begin
         m  = m >> 1;
         be = be + 1;
      end
      if (be >= 255) return {s, 8'hFF, 23'd0};
      if (be <= 0) return {s, 31'd0};
      return {s, be[7:0], m[22:0]};
   endfunction

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction
   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 0);
   endfunction
   function automatic logic is_zero(input logic [31:0] x);
      return x[30:23] == 8'h00;
   endfunction

   function automatic logic [31:0] product_of(input logic [31:0] a, input logic [31:0] b);
      logic s;
      logic [319:0] ma, mb;
      s = a[31] ^ b[31];
      if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
      if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) return 32'h7FC0_0000;
      if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'd0};
      if (is_zero(a) || is_zero(b)) return {s, 31'd0};
      ma = 320'({1'b1, a[22:0]});
      mb = 320'({1'b1, b[22:0]});
      return round_pack(s, ma * mb, int'(a[30:23]) + int'(b[30:23]) - 300);
   endfunction

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      logic [31:0] p;
      logic sp, sn;
      int emin;
      logic [319:0] vp, vc;
      p = product_of(a, b);
      if (is_nan(p) || is_nan(c)) return 32'h7FC0_0000;
      sp = p[31];
      sn = ~c[31];
      if (is_inf(p) && is_inf(c)) return (sp != sn) ? 32'h7FC0_0000 : p;
      if (is_inf(p)) return p;
      if (is_inf(c)) return {sn, 8'hFF, 23'd0};
      if (is_zero(p) && is_zero(c)) return {sp & sn, 31'd0};
      if (is_zero(p)) return {sn, c[30:0]};
      if (is_zero(c)) return p;
      emin = (p[30:23] < c[30:23]) ? int'(p[30:23]) : int'(c[30:23]);
      vp = 320'({1'b1, p[22:0]}) << (int'(p[30:23]) - emin);
      vc = 320'({1'b1, c[22:0]}) << (int'(c[30:23]) - emin);
      if (sp == sn) return round_pack(sp, vp + vc, emin - 150);
      if (vp > vc) return round_pack(sp, vp - vc, emin - 150);
      if (vc > vp) return round_pack(sn, vc - vp, emin - 150);
      return 32'h0000_0000;
   endfunction

   function automatic logic [31:0] rf(input int lo, input int hi);
      logic [7:0] e;
      e = 8'($urandom_range(hi, lo));
      return {1'($urandom_range(1, 0)), e, 23'($urandom)};
   endfunction

   function automatic logic [31:0] special();
      logic [31:0] tbl [8];
      tbl = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
              32'h7FC0_0001, 32'h0001_2345, 32'h3F80_0000, 32'h7F7F_FFFF};
      return tbl[$urandom_range(7, 0)];
   endfunction

   task automatic drive(input logic r, input logic en, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
      rst = r; EN = en; A = a; B = b; C = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
      vectors++;
      if (result !== 32'h0) begin
         errors++;
         $display("FAIL reset_state: result=%h expected=%h", result, 32'h0);
      end
      drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic test_directed();
      logic [31:0] va [5] = '{32'h4000_0000, 32'h40CC_CCCC, 32'h3FC0_0000, 32'h7F80_0000, 32'h7F00_0000};
      logic [31:0] vb [5] = '{32'h4040_0000, 32'hBF00_0000, 32'h4000_0000, 32'h0000_0000, 32'h4000_0000};
      logic [31:0] vc [5] = '{32'h3F80_0000, 32'h404C_CCCC, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000};
      logic [31:0] ve [5] = '{32'h40A0_0000, 32'hC0CC_CCCC, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000};
      for (int i = 0; i <= 5; i++) begin
         if (i < 5) drive(1'b0, 1'b1, va[i], vb[i], vc[i]);
         else       drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
         if (i > 0) begin
            vectors++;
            if (result !== ve[i-1]) begin
               errors++;
               $display("FAIL directed_%0d: result=%h expected=%h", i - 1, result, ve[i-1]);
            end
         end
      end
   endtask

   task automatic test_random(input int n);
      logic [31:0] a, b, c, p, prev;
      int mode, e;
      for (int i = 0; i <= n; i++) begin
         mode = int'($urandom_range(11, 0));
         a = rf(90, 164);
         b = rf(90, 164);
         if (mode == 0) a = special();
         if (mode == 1) b = special();
         if (mode == 8) begin a = rf(1, 60); b = rf(1, 120); end
         if (mode == 9) begin a = rf(200, 254); b = rf(150, 254); end
         p = product_of(a, b);
         case (mode)
            2:       c = special();
            3:       c = p;
            4:       c = p ^ 32'h1;
            5:       c = {~p[31], p[30:0]};
            6:       c = $urandom;
            7:       c = rf(1, 254);
            default: begin
               e = int'(p[30:23]) + int'($urandom_range(60, 0)) - 30;
               if (e < 1) e = 1;
               if (e > 254) e = 254;
               c = {1'($urandom_range(1, 0)), 8'(e), 23'($urandom)};
            end
         endcase
         if (i == n) begin a = '0; b = '0; c = '0; end
         drive(1'b0, 1'b1, a, b, c);
         if (i > 0) begin
            vectors++;
            if (result !== prev) begin
               errors++;
               $display("FAIL random_%0d: result=%h expected=%h", i - 1, result, prev);
            end
         end
         prev = model(a, b, c);
      end
   endtask

   task automatic test_stall();
      logic [31:0] xa, xb, xc, ya, yb, yc, hold;
      xa = rf(110, 140); xb = rf(110, 140); xc = rf(100, 150);
      ya = rf(110, 140); yb = rf(110, 140); yc = rf(100, 150);
      drive(1'b0, 1'b1, xa, xb, xc);
      hold = result;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, $urandom, $urandom, $urandom);
         vectors++;
         if (result !== hold) begin
            errors++;
            $display("FAIL stall_hold_%0d: result=%h expected=%h", i, result, hold);
         end
      end
      drive(1'b0, 1'b1, ya, yb, yc);
      vectors++;
      if (result !== model(xa, xb, xc)) begin
         errors++;
         $display("FAIL stall_resume_x: result=%h expected=%h", result, model(xa, xb, xc));
      end
      drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      vectors++;
      if (result !== model(ya, yb, yc)) begin
         errors++;
         $display("FAIL stall_resume_y: result=%h expected=%h", result, model(ya, yb, yc));
      end
   endtask

   task automatic test_reset_midflight();
      drive(1'b0, 1'b1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
      drive(1'b1, 1'b1, 32'h4000_0000, 32'h4040_0000, 32'h3F80_0000);
      vectors++;
      if (result !== 32'h0) begin
         errors++;
         $display("FAIL reset_priority: result=%h expected=%h", result, 32'h0);
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
         vectors++;
         if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_flush_%0d: result=%h expected=%h", i, result, 32'h0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; EN = 1'b0; A = '0; B = '0; C = '0;
      test_reset();
      test_directed();
      test_random(600);
      test_stall();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
